// File: rtl/zoom_frame_sequencer_if.sv
// Handshake and coordinate bundle between the zoom frame sequencer and its camera/core/consumer.
// master = sequencer side, slave = surrounding datapath.
interface zoom_frame_sequencer_if #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int ZW = 4
);
  logic [ZW-1:0] zoom_req;
  logic          pixel_in_valid;
  logic          pixel_in_ready;
  logic          wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic          proc_start;
  logic          proc_done;
  logic [ZW-1:0] zoom_cur;
  logic          rd_en;
  logic          rd_valid;
  logic          rd_ready;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          busy;
  logic          frame_done;
  logic          error;

  modport master (
    input  zoom_req, pixel_in_valid, proc_done, rd_ready,
    output pixel_in_ready, wr_en, wr_x, wr_y, proc_start, zoom_cur,
           rd_en, rd_valid, rd_x, rd_y, busy, frame_done, error
  );

  modport slave (
    output zoom_req, pixel_in_valid, proc_done, rd_ready,
    input  pixel_in_ready, wr_en, wr_x, wr_y, proc_start, zoom_cur,
           rd_en, rd_valid, rd_x, rd_y, busy, frame_done, error
  );
endinterface

// File: rtl/zoom_frame_sequencer.sv
// Capture -> process -> readout sequencer for one quad-zoom frame.
// Optional PROCESS watchdog enabled by defining ZOOM_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | waiting for first pixel of a frame; zoom latched on its acceptance
// CAPTURE | writing incoming pixels in raster order
// PROCESS | zoom pass launched, waiting for proc_done
// READOUT | presenting raster-ordered read coordinates
module zoom_frame_sequencer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MAX_ZOOM   = 8,
  parameter int WD_CYCLES  = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  zoom_frame_sequencer_if.master bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int ZW = $clog2(MAX_ZOOM + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, PROCESS, READOUT} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [ZW-1:0] zoom_q;
  logic [ZW-1:0] zoom_clamped;
  logic          proc_first;
  logic          ready_int, rd_valid_int, rd_en_int;
  logic          accept, step, x_last, y_last, done_ok, wd_expire;

  assign x_last    = (x_cnt == XW'(IMG_WIDTH - 1));
  assign y_last    = (y_cnt == YW'(IMG_HEIGHT - 1));
  assign accept    = bus.pixel_in_valid & ready_int;
  assign rd_en_int = rd_valid_int & bus.rd_ready;
  // write and read phases never overlap, so one coordinate counter serves both
  assign step      = accept | rd_en_int;
  assign done_ok   = ~proc_first & bus.proc_done;

  always_comb begin
    zoom_clamped = bus.zoom_req;
    if (bus.zoom_req < ZW'(2))
      zoom_clamped = ZW'(2);
    else if (bus.zoom_req > ZW'(MAX_ZOOM))
      zoom_clamped = ZW'(MAX_ZOOM);
  end

  always_comb begin
    state_nxt    = state;
    ready_int    = 1'b0;
    rd_valid_int = 1'b0;
    case (state)
      IDLE: begin
        ready_int = ~reset;
        if (accept) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        ready_int = ~reset;
        if (accept && x_last && y_last) state_nxt = PROCESS;
      end
      PROCESS: begin
        if (done_ok)        state_nxt = READOUT;
        else if (wd_expire) state_nxt = IDLE;
      end
      READOUT: begin
        rd_valid_int = 1'b1;
        if (rd_en_int && x_last && y_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      zoom_q     <= ZW'(2);
      proc_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      proc_first <= (state != PROCESS) && (state_nxt == PROCESS);
      if (state == IDLE && accept) zoom_q <= zoom_clamped;
      if (step) begin
        if (x_last) begin
          x_cnt <= '0;
          y_cnt <= y_last ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

`ifdef ZOOM_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          err_q;

  assign wd_expire = (state == PROCESS) && (wd_cnt == WW'(WD_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == PROCESS) ? wd_cnt + 1'b1 : '0;
      if (wd_expire && !done_ok) err_q <= 1'b1;
    end
  end

  assign bus.error = err_q;
`else
  assign wd_expire = 1'b0;
  assign bus.error = 1'b0;
`endif

  assign bus.pixel_in_ready = ready_int;
  assign bus.wr_en          = accept;
  assign bus.wr_x           = x_cnt;
  assign bus.wr_y           = y_cnt;
  assign bus.proc_start     = (state == PROCESS) && proc_first;
  assign bus.zoom_cur       = zoom_q;
  assign bus.rd_valid       = rd_valid_int;
  assign bus.rd_en          = rd_en_int;
  assign bus.rd_x           = x_cnt;
  assign bus.rd_y           = y_cnt;
  assign bus.busy           = (state != IDLE);
  assign bus.frame_done     = rd_en_int & x_last & y_last;
endmodule
